// File: rtl/noc_endpoint_ni.sv
// noc_endpoint_ni -- tile-side network interface for one NoC endpoint channel.
//
// TX: a packet request (vc, header payload, length) is latched and sent as a
// header flit followed by len-1 body flits taken from the tx_data handshake.
// The last flit carries the tail bit. A flit on a VC is only sent while that
// VC's credit counter is non-zero. Counters start at B and are replenished by
// credit_in.
// RX: incoming flits go into a V*B deep FIFO. Every pop returns one credit to
// the router on the popped flit's VC.
//
// Flit layout: [Fw-1] hdr, [Fw-2] tail, [Fw-3:Dw] VC one-hot, [Dw-1:0] payload.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   flit_out/_wr        registered flit to router, _wr high one cycle per flit
//   credit_in[V]        credit returned by router
//   flit_in/_wr         flit from router
//   credit_out[V]       registered one-cycle credit pulse per popped flit
//   pkt_req/vc/hdr/len  packet request, held until pkt_ack (len 0 means 1)
//   pkt_ack             one-cycle acceptance pulse
//   tx_data/_valid/_ready  body payload handshake
//   tx_busy             TX FSM not idle
//   rx_flit/rx_valid/rx_ready  RX FIFO head and pop handshake
//   err[1:0]            sticky: [0] credit overflow, [1] RX FIFO overflow
module noc_endpoint_ni #(
  parameter int V       = 4,
  parameter int B       = 4,
  parameter int Dw      = 32,
  parameter int MAX_LEN = 16,
  parameter int Fw      = 2 + V + Dw,
  parameter int Vw      = $clog2(V),
  parameter int LENw    = $clog2(MAX_LEN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [Fw-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic [V-1:0]    credit_in,
  input  logic [Fw-1:0]   flit_in,
  input  logic            flit_in_wr,
  output logic [V-1:0]    credit_out,
  input  logic            pkt_req,
  input  logic [Vw-1:0]   pkt_vc,
  input  logic [Dw-1:0]   pkt_hdr,
  input  logic [LENw-1:0] pkt_len,
  output logic            pkt_ack,
  input  logic [Dw-1:0]   tx_data,
  input  logic            tx_data_valid,
  output logic            tx_data_ready,
  output logic            tx_busy,
  output logic [Fw-1:0]   rx_flit,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [1:0]      err
);

  localparam int Cw    = $clog2(B + 1);
  localparam int DEPTH = V * B;
  localparam int Aw    = $clog2(DEPTH);
  localparam int Nw    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;

  state_t          state_q, state_d;
  logic [Vw-1:0]   vc_q, vc_d;
  logic [Dw-1:0]   hdr_q, hdr_d;
  logic [LENw-1:0] len_q, len_d;
  logic [LENw-1:0] rem_q, rem_d;
  logic            ack_q, ack_d;
  logic [Fw-1:0]   flit_q, flit_d;
  logic            wr_q, wr_d;
  logic [Cw-1:0]   credit_q [V];
  logic [Cw-1:0]   credit_d [V];
  logic [1:0]      err_q, err_d;
  logic [V-1:0]    cout_q, cout_d;
  logic [V-1:0]    vc_oh, send_oh;
  logic            credit_ok;

  // RX FIFO
  logic [Fw-1:0]   mem [DEPTH];
  logic [Aw-1:0]   rd_q, rd_d, wp_q, wp_d;
  logic [Nw-1:0]   cnt_q, cnt_d;
  logic            full, push, pop, rx_ovf;

  assign vc_oh     = V'(1) << vc_q;
  assign credit_ok = (credit_q[vc_q] != '0);
  assign send_oh   = wr_d ? vc_oh : '0;

  // ---------------- TX FSM ----------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skipped one would infer a latch.
    state_d = state_q;
    vc_d    = vc_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    rem_d   = rem_q;
    ack_d   = 1'b0;
    wr_d    = 1'b0;
    flit_d  = flit_q;
    unique case (state_q)
      S_IDLE: begin
        if (pkt_req) begin
          vc_d    = pkt_vc;
          hdr_d   = pkt_hdr;
          len_d   = (pkt_len == '0) ? LENw'(1) : pkt_len;
          ack_d   = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (credit_ok) begin
          wr_d    = 1'b1;
          flit_d  = {1'b1, len_q == LENw'(1), vc_oh, hdr_q};
          rem_d   = len_q - LENw'(1);
          state_d = (len_q == LENw'(1)) ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        if (tx_data_valid && credit_ok) begin
          wr_d   = 1'b1;
          flit_d = {1'b0, rem_q == LENw'(1), vc_oh, tx_data};
          rem_d  = rem_q - LENw'(1);
          if (rem_q == LENw'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------- credits and sticky errors -------------
  // A send and a returned credit on the same VC cancel, so a counter at B
  // that also sends this cycle does not flag an overflow.
  always_comb begin
    err_d = err_q | {rx_ovf, 1'b0};
    for (int v = 0; v < V; v++) begin
      credit_d[v] = credit_q[v];
      if (credit_in[v] && !send_oh[v]) begin
        if (credit_q[v] == Cw'(B)) err_d[0] = 1'b1;
        else                       credit_d[v] = credit_q[v] + Cw'(1);
      end else if (send_oh[v] && !credit_in[v]) begin
        credit_d[v] = credit_q[v] - Cw'(1);
      end
    end
  end

  // ---------------- RX FIFO ----------------
  assign full   = (cnt_q == Nw'(DEPTH));
  assign pop    = rx_valid && rx_ready;
  assign push   = flit_in_wr && (!full || pop);
  assign rx_ovf = flit_in_wr && full && !pop;

  always_comb begin
    rd_d   = rd_q;
    wp_d   = wp_q;
    cout_d = '0;
    if (pop) begin
      rd_d   = (rd_q == Aw'(DEPTH - 1)) ? '0 : rd_q + Aw'(1);
      cout_d = mem[rd_q][Fw-3:Dw];
    end
    if (push) wp_d = (wp_q == Aw'(DEPTH - 1)) ? '0 : wp_q + Aw'(1);
    cnt_d = cnt_q + Nw'(push) - Nw'(pop);
  end

  // NOTE: flops use non-blocking assignments so each one samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vc_q    <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
      flit_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= '0;
      cout_q  <= '0;
      rd_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      for (int v = 0; v < V; v++) credit_q[v] <= Cw'(B);
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      flit_q  <= flit_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cout_q  <= cout_d;
      rd_q    <= rd_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      for (int v = 0; v < V; v++) credit_q[v] <= credit_d[v];
    end
  end

  // NOTE: FIFO storage has no reset; the count and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= flit_in;
  end

  assign flit_out      = flit_q;
  assign flit_out_wr   = wr_q;
  assign pkt_ack       = ack_q;
  assign credit_out    = cout_q;
  assign err           = err_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign tx_data_ready = (state_q == S_BODY) && credit_ok;
  assign rx_valid      = (cnt_q != '0);
  assign rx_flit       = mem[rd_q];

endmodule

// File: tb/tb_noc_endpoint_ni.sv
// Testbench for noc_endpoint_ni. Inputs change 1 time unit after the rising
// edge and outputs are sampled there too. tick() advances one clock and
// compares the DUT against a queue/counter model of the endpoint: expected TX
// flits in order, per-VC credit counts, RX FIFO contents, credit pulses and
// sticky error bits.
module tb_noc_endpoint_ni;

  localparam int V       = 4;
  localparam int B       = 4;
  localparam int Dw      = 32;
  localparam int MAX_LEN = 16;
  localparam int Fw      = 2 + V + Dw;
  localparam int Vw      = $clog2(V);
  localparam int LENw    = $clog2(MAX_LEN + 1);
  localparam int DEPTH   = V * B;

  typedef logic [Fw-1:0] flit_t;

  typedef struct {
    logic [Vw-1:0]   vc;
    logic [LENw-1:0] len;
    logic [Dw-1:0]   hdr;
    logic [Dw-1:0]   base;
    flit_t           exp_hdr;
  } tx_vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  flit_t           flit_out;
  logic            flit_out_wr;
  logic [V-1:0]    credit_in = '0;
  flit_t           flit_in = '0;
  logic            flit_in_wr = 1'b0;
  logic [V-1:0]    credit_out;
  logic            pkt_req = 1'b0;
  logic [Vw-1:0]   pkt_vc = '0;
  logic [Dw-1:0]   pkt_hdr = '0;
  logic [LENw-1:0] pkt_len = '0;
  logic            pkt_ack;
  logic [Dw-1:0]   tx_data = '0;
  logic            tx_data_valid = 1'b0;
  logic            tx_data_ready;
  logic            tx_busy;
  flit_t           rx_flit;
  logic            rx_valid;
  logic            rx_ready = 1'b0;
  logic [1:0]      err;

  always #5 clk = ~clk;

  noc_endpoint_ni dut (
    .clk           (clk),
    .reset         (reset),
    .flit_out      (flit_out),
    .flit_out_wr   (flit_out_wr),
    .credit_in     (credit_in),
    .flit_in       (flit_in),
    .flit_in_wr    (flit_in_wr),
    .credit_out    (credit_out),
    .pkt_req       (pkt_req),
    .pkt_vc        (pkt_vc),
    .pkt_hdr       (pkt_hdr),
    .pkt_len       (pkt_len),
    .pkt_ack       (pkt_ack),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .tx_busy       (tx_busy),
    .rx_flit       (rx_flit),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .err           (err)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  flit_t      exp_tx[$];
  flit_t      rxq[$];
  int         mcred[V];
  logic [1:0] exp_err;
  bit         auto_credit = 1'b1;
  bit         rx_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [V-1:0] oh(input logic [Vw-1:0] v);
    return V'(1) << v;
  endfunction

  task automatic reset_model();
    exp_tx.delete();
    rxq.delete();
    exp_err = '0;
    for (int v = 0; v < V; v++) mcred[v] = B;
  endtask

  // One clock: capture what the edge will sample, advance, then compare.
  task automatic tick();
    logic [V-1:0] cin, dec;
    logic         push, pop;
    flit_t        fin, popped;
    cin  = credit_in;
    push = flit_in_wr;
    fin  = flit_in;
    pop  = (rxq.size() != 0) && rx_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      reset_model();
      credit_in = '0;
      return;
    end
    dec = '0;
    if (flit_out_wr) begin
      if (exp_tx.size() == 0) begin
        check("tx_unexpected", flit_out_wr, 0);
      end else begin
        popped = exp_tx.pop_front();
        check("tx_flit", flit_out, popped);
        dec = popped[Fw-3:Dw];
      end
    end
    for (int v = 0; v < V; v++) begin
      if (dec[v]) check("tx_credit_respected", mcred[v] > 0, 1);
      if (cin[v] && !dec[v]) begin
        if (mcred[v] == B) exp_err[0] = 1'b1;
        else               mcred[v]++;
      end else if (dec[v] && !cin[v]) begin
        mcred[v]--;
      end
    end
    if (pop) begin
      popped = rxq.pop_front();
      check("credit_out", credit_out, popped[Fw-3:Dw]);
    end else begin
      check("credit_out_idle", credit_out, 0);
    end
    if (push) begin
      if (rxq.size() < DEPTH) rxq.push_back(fin);
      else                    exp_err[1] = 1'b1;
    end
    check("rx_valid", rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) check("rx_flit", rx_flit, rxq[0]);
    check("err", err, exp_err);
    credit_in = auto_credit ? dec : '0;
    if (rx_rand) begin
      flit_in_wr = 1'($urandom_range(0, 1));
      flit_in    = {2'($urandom), oh(Vw'($urandom)), Dw'($urandom)};
      rx_ready   = 1'($urandom_range(0, 1));
    end
  endtask

  // Full packet: request, check ack and header latency, stream body
  // payloads base*k, wait for the tail. Credits must be available.
  task automatic send_pkt(input logic [Vw-1:0] vc, input logic [LENw-1:0] len,
                          input logic [Dw-1:0] hdr, input flit_t exp_hdr,
                          input logic [Dw-1:0] base, input bit bubbles);
    int n, k, guard;
    bit hs;
    n = (len == '0) ? 1 : int'(len);
    exp_tx.push_back(exp_hdr);
    for (int i = 1; i < n; i++)
      exp_tx.push_back({1'b0, i == n - 1, oh(vc), base * Dw'(i)});
    pkt_req = 1'b1;
    pkt_vc  = vc;
    pkt_hdr = hdr;
    pkt_len = len;
    tick();
    check("pkt_ack", pkt_ack, 1);
    check("tx_busy", tx_busy, 1);
    check("hdr_not_early", flit_out_wr, 0);
    pkt_req = 1'b0;
    pkt_vc  = Vw'($urandom);
    pkt_hdr = Dw'($urandom);
    pkt_len = LENw'($urandom);
    tick();
    check("pkt_ack_pulse", pkt_ack, 0);
    check("hdr_latency", flit_out_wr, 1);
    k = 1;
    guard = 0;
    while ((k < n || exp_tx.size() != 0) && guard < 400) begin
      tx_data_valid = (k < n) && (!bubbles || $urandom_range(0, 3) != 0);
      tx_data       = base * Dw'(k);
      hs            = tx_data_valid && tx_data_ready;
      tick();
      guard++;
      if (hs) k++;
    end
    tx_data_valid = 1'b0;
    check("pkt_drained", exp_tx.size(), 0);
    check("tx_idle_after_tail", tx_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_vec_t         vecs[6];
    logic [V-1:0]    seen[$];
    logic [V-1:0]    exp_seq[3];
    logic [Vw-1:0]   rvc;
    logic [LENw-1:0] rlen;
    logic [Dw-1:0]   rhdr, rbase;
    int              rn, guard;

    vecs[0] = '{vc: 2'd2, len: 5'd1,  hdr: 32'h0000_00A5, base: 32'h0,  exp_hdr: 38'h34_0000_00A5};
    vecs[1] = '{vc: 2'd0, len: 5'd3,  hdr: 32'h0000_0C0D, base: 32'h11, exp_hdr: 38'h21_0000_0C0D};
    vecs[2] = '{vc: 2'd3, len: 5'd0,  hdr: 32'hDEAD_BEEF, base: 32'h5,  exp_hdr: 38'h38_DEAD_BEEF};
    vecs[3] = '{vc: 2'd1, len: 5'd2,  hdr: 32'h1234_5678, base: 32'h7,  exp_hdr: 38'h22_1234_5678};
    vecs[4] = '{vc: 2'd3, len: 5'd16, hdr: 32'h0000_0000, base: 32'h3,  exp_hdr: 38'h28_0000_0000};
    vecs[5] = '{vc: 2'd0, len: 5'd1,  hdr: 32'hFFFF_FFFF, base: 32'h1,  exp_hdr: 38'h31_FFFF_FFFF};
    exp_seq = '{4'b0010, 4'b0001, 4'b0010};

    // reset state
    reset_model();
    tick();
    tick();
    check("rst_flit_out", flit_out, 0);
    check("rst_flit_out_wr", flit_out_wr, 0);
    check("rst_credit_out", credit_out, 0);
    check("rst_pkt_ack", pkt_ack, 0);
    check("rst_err", err, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_data_ready, 0);
    reset = 1'b0;
    tick();

    // table-driven packets, router returns credits immediately
    auto_credit = 1'b1;
    for (int i = 0; i < 6; i++)
      send_pkt(vecs[i].vc, vecs[i].len, vecs[i].hdr, vecs[i].exp_hdr, vecs[i].base, 1'b0);

    // credit stall: four packets drain vc1, the fifth waits in HDR
    auto_credit = 1'b0;
    for (int i = 0; i < 4; i++)
      send_pkt(2'd1, 5'd1, 32'h50 + i, {1'b1, 1'b1, 4'b0010, 32'h50 + i}, 32'h0, 1'b0);
    exp_tx.push_back({1'b1, 1'b1, 4'b0010, 32'h55});
    pkt_req = 1'b1; pkt_vc = 2'd1; pkt_len = 5'd1; pkt_hdr = 32'h55;
    tick();
    check("stall_ack", pkt_ack, 1);
    pkt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", flit_out_wr, 0);
      check("stall_busy", tx_busy, 1);
    end
    credit_in = 4'b0010;
    tick();
    check("stall_credit_edge", flit_out_wr, 0);
    tick();
    check("stall_release", flit_out_wr, 1);
    for (int i = 0; i < 4; i++) begin
      credit_in = 4'b0010;
      tick();
    end
    check("stall_err_clear", err[0], 0);

    // send and credit return on vc3 in the same cycle, then overflow at B
    exp_tx.push_back({1'b1, 1'b1, 4'b1000, 32'h33});
    pkt_req = 1'b1; pkt_vc = 2'd3; pkt_len = 5'd1; pkt_hdr = 32'h33;
    tick();
    pkt_req = 1'b0;
    credit_in = 4'b1000;
    tick();
    check("simul_send", flit_out_wr, 1);
    check("simul_no_err", err[0], 0);
    credit_in = 4'b1000;
    tick();
    check("sat_err", err[0], 1);
    auto_credit = 1'b1;

    // RX: three flits popped as they arrive
    rx_ready = 1'b1;
    flit_in_wr = 1'b1;
    flit_in = {2'b00, 4'b0010, 32'h1};
    tick(); if (credit_out != '0) seen.push_back(credit_out);
    flit_in = {2'b10, 4'b0001, 32'h2};
    tick(); if (credit_out != '0) seen.push_back(credit_out);
    flit_in = {2'b01, 4'b0010, 32'h3};
    tick(); if (credit_out != '0) seen.push_back(credit_out);
    flit_in_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (credit_out != '0) seen.push_back(credit_out);
    end
    check("rx_credit_count", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      check("rx_credit_order", (i < seen.size()) ? seen[i] : '0, exp_seq[i]);

    // RX: fill, push+pop while full, then overflow
    rx_ready = 1'b0;
    flit_in_wr = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      flit_in = {2'b00, oh(Vw'(i)), Dw'(32'h100 + i)};
      tick();
    end
    check("rx_full_no_err", err[1], 0);
    rx_ready = 1'b1;
    flit_in = {2'b00, 4'b0100, 32'h77};
    tick();
    check("rx_full_pushpop_no_err", err[1], 0);
    rx_ready = 1'b0;
    flit_in = {2'b00, 4'b1000, 32'h99};
    tick();
    check("rx_ovf_err", err[1], 1);
    flit_in_wr = 1'b0;
    rx_ready = 1'b1;
    guard = 0;
    while (rx_valid && guard < 40) begin
      tick();
      guard++;
    end
    check("rx_drained", rx_valid, 0);

    // randomized packets with concurrent random RX traffic
    rx_rand = 1'b1;
    for (int p = 0; p < 25; p++) begin
      rvc   = Vw'($urandom);
      rlen  = LENw'($urandom_range(0, MAX_LEN));
      rhdr  = Dw'($urandom);
      rbase = Dw'($urandom);
      rn    = (rlen == '0) ? 1 : int'(rlen);
      send_pkt(rvc, rlen, rhdr, {1'b1, rn == 1, oh(rvc), rhdr}, rbase, 1'b1);
    end
    rx_rand = 1'b0;
    flit_in_wr = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    // reset asserted mid-BODY
    auto_credit = 1'b0;
    exp_tx.push_back({1'b1, 1'b0, 4'b0001, 32'hAB});
    exp_tx.push_back({1'b0, 1'b0, 4'b0001, 32'h100});
    exp_tx.push_back({1'b0, 1'b0, 4'b0001, 32'h200});
    pkt_req = 1'b1; pkt_vc = 2'd0; pkt_len = 5'd6; pkt_hdr = 32'hAB;
    tick();
    pkt_req = 1'b0;
    tick();
    tx_data_valid = 1'b1;
    tx_data = 32'h100;
    tick();
    tx_data = 32'h200;
    tick();
    check("mid_body_wr", flit_out_wr, 1);
    check("mid_body_busy", tx_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_wr", flit_out_wr, 0);
    check("async_rst_busy", tx_busy, 0);
    check("async_rst_err", err, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    check("async_rst_flit", flit_out, 0);
    tx_data_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", flit_out_wr, 0);
    // all four credits on vc0 are back: four packets go without stalling
    for (int i = 0; i < 4; i++)
      send_pkt(2'd0, 5'd1, 32'hC0 + i, {1'b1, 1'b1, 4'b0001, 32'hC0 + i}, 32'h0, 1'b0);

    check("tx_queue_empty", exp_tx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
